aes_decrypt_iter: RTL and testbench

//  Iterative AES-128 inverse cipher (FIPS-197 sec. 5.3). It is the receive-side counterpart of the

---
 rtl/aes_pkg.sv | 156 +++++++++++++++
 rtl/aes_inv_round.sv | 26 ++
 rtl/aes_decrypt_iter.sv | 152 +++++++++++++++
 tb/tb_aes_decrypt_iter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
//   Shared AES-128 definitions for the iterative inverse cipher:
//   - AES_NR                : round count (AES-128 only)
//   - aes_state_e           : controller state encoding
//   - SBOX / INV_SBOX       : byte substitution tables, entry 0 in the top byte
//   - xtime, sbox, inv_sbox, sub_word, rot_word, rcon, key_expand
//   - inv_shift_rows, inv_sub_bytes, inv_mix_column, inv_mix_columns
//   Block/word byte order: byte 0 is the most significant byte, column-major.
// -----------------------------------------------------------------------------
package aes_pkg;

  localparam int AES_NR = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KEYEXP = 3'd1,
    ST_INIT   = 3'd2,
    ST_ROUND  = 3'd3,
    ST_FINAL  = 3'd4,
    ST_DONE   = 3'd5
  } aes_state_e;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Entry x sits at bit offset 8*(255-x), which is {~x, 3'b000}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // One AES-128 schedule step: four words of round key i from round key i-1.
  function automatic logic [127:0] key_expand(input logic [127:0] prev, input logic [7:0] rc);
    logic [31:0] t;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;
    t  = sub_word(rot_word(prev[31:0])) ^ {rc, 24'h000000};
    w0 = prev[127:96] ^ t;
    w1 = prev[95:64]  ^ w0;
    w2 = prev[63:32]  ^ w1;
    w3 = prev[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Row r of column c moves right by r: out[r][c] = in[r][(c - r) mod 4].
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127 - 8*(row + 4*c) -: 8] = s[127 - 8*(row + 4*((c - row + 4) % 4)) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = 128'h0;
    for (int i = 0; i < 16; i++) begin
      r[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
    end
    return r;
  endfunction

  // Multiples 9, b, d, e built from the xtime chain x2 -> x4 -> x8.
  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31 - 8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    r = 128'h0;
    for (int c = 0; c < 4; c++) begin
      r[127 - 32*c -: 32] = inv_mix_column(s[127 - 32*c -: 32]);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// -----------------------------------------------------------------------------
// aes_inv_round
//   Combinational AES inverse round.
//   state_i    : 128-bit round input state
//   rk_i       : 128-bit round key
//   is_final_i : 1 = last round (InvMixColumns bypassed)
//   state_o    : 128-bit round output state
//   state_o = [InvMixColumns](InvSubBytes(InvShiftRows(state_i)) ^ rk_i)
// -----------------------------------------------------------------------------
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rk_i,
  input  logic         is_final_i,
  output logic [127:0] state_o
);

  logic [127:0] keyed_s;
  logic [127:0] mixed_s;

  assign keyed_s = inv_sub_bytes(inv_shift_rows(state_i)) ^ rk_i;
  assign mixed_s = inv_mix_columns(keyed_s);
  assign state_o = is_final_i ? keyed_s : mixed_s;

endmodule

// File: rtl/aes_decrypt_iter.sv
// -----------------------------------------------------------------------------
// aes_decrypt_iter
//   Iterative AES-128 inverse cipher, one round per clock, with a one-entry
//   expanded-key cache.
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   in_valid  / in_ready  / in_block / key : ciphertext + key handshake
//   out_valid / out_ready / out_block      : plaintext handshake
//   Flow: IDLE -> KEYEXP (10, skipped on cache hit) -> INIT -> ROUND (9)
//         -> FINAL -> DONE -> IDLE.
// -----------------------------------------------------------------------------
module aes_decrypt_iter
  import aes_pkg::*;
#(
  parameter int NR        = AES_NR,
  parameter int KEY_CACHE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block
);

  if (NR != AES_NR) begin : g_nr_check
    $error("aes_decrypt_iter: only NR = 10 (AES-128) is supported");
  end

  localparam logic [3:0] LAST_RND = 4'(NR);

  aes_state_e   state_q;
  logic [3:0]   cnt_q;        // key index during KEYEXP, round number afterwards
  logic [127:0] blk_q;        // latched ciphertext, then the working state
  logic [127:0] rk_q [0:NR];  // rk_q[0] doubles as the cached key
  logic         cache_vld_q;
  logic         in_ready_q;
  logic         out_valid_q;
  logic [127:0] out_block_q;

  logic         accept_s;
  logic         key_hit_s;
  logic [3:0]   prev_idx_s;
  logic [127:0] key_exp_s;
  logic [127:0] round_key_s;
  logic         is_final_s;
  logic [127:0] round_s;

  assign accept_s    = (state_q == ST_IDLE) && in_valid && in_ready_q;
  // Cache is only ever valid once the schedule is complete, so a hit always
  // refers to a fully expanded key.
  assign key_hit_s   = (KEY_CACHE != 0) && cache_vld_q && (key == rk_q[0]);
  assign prev_idx_s  = (cnt_q == 4'd0) ? 4'd0 : (cnt_q - 4'd1);
  assign key_exp_s   = key_expand(rk_q[prev_idx_s], rcon(cnt_q));
  assign round_key_s = rk_q[cnt_q];
  assign is_final_s  = (state_q == ST_FINAL);

  aes_inv_round u_inv_round (
    .state_i    (blk_q),
    .rk_i       (round_key_s),
    .is_final_i (is_final_s),
    .state_o    (round_s)
  );

  // Round-key storage: key on a miss accept, then one expanded key per KEYEXP cycle.
  always_ff @(posedge clk) begin
    if (rst_n && accept_s && !key_hit_s) begin
      rk_q[0] <= key;
    end else if (rst_n && (state_q == ST_KEYEXP)) begin
      rk_q[cnt_q] <= key_exp_s;
    end
  end

  // Controller, datapath state and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      blk_q       <= 128'h0;
      cache_vld_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_block_q <= 128'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            blk_q      <= in_block;
            in_ready_q <= 1'b0;
            if (key_hit_s) begin
              state_q <= ST_INIT;
            end else begin
              // rk_q[0] is being overwritten, so the cache is stale until
              // the new schedule finishes.
              state_q     <= ST_KEYEXP;
              cnt_q       <= 4'd1;
              cache_vld_q <= 1'b0;
            end
          end
        end
        ST_KEYEXP: begin
          if (cnt_q == LAST_RND) begin
            state_q     <= ST_INIT;
            cache_vld_q <= (KEY_CACHE != 0);
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ST_INIT: begin
          blk_q   <= blk_q ^ rk_q[NR];
          cnt_q   <= LAST_RND - 4'd1;
          state_q <= ST_ROUND;
        end
        ST_ROUND: begin
          // Counter ends at 0 so FINAL picks up rk_q[0].
          blk_q <= round_s;
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= ST_FINAL;
          end
        end
        ST_FINAL: begin
          out_block_q <= round_s;
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          cnt_q       <= 4'd0;
          cache_vld_q <= 1'b0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_block = out_block_q;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// -----------------------------------------------------------------------------
// tb_aes_decrypt_iter
//   Self-checking bench for aes_decrypt_iter. The reference is a forward
//   AES-128 encryptor built from GF(2^8) arithmetic (S-box derived from field
//   inverses), so decrypting its ciphertext must return the original plaintext.
//   Latency is counted in clock edges, the accept edge being edge 1, up to and
//   including the edge that raises out_valid.
// -----------------------------------------------------------------------------
module tb_aes_decrypt_iter;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;

  int n_tests;
  int n_fail;

  logic [7:0]   sbox_m [256];
  logic [127:0] cache_key;
  bit           cache_ok;

  aes_decrypt_iter #(.NR(10), .KEY_CACHE(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-box = affine transform of the multiplicative inverse in GF(2^8).
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] bx;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      bx  = x[7:0];
      for (int y = 1; y < 256; y++) begin
        if (gmul(bx, y[7:0]) == 8'h01) inv = y[7:0];
      end
      sbox_m[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] pt);
    logic [31:0]  w   [44];
    logic [7:0]   st  [16];
    logic [7:0]   tmp [16];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) st[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) st[i] = sbox_m[st[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          tmp[row + 4*c] = st[row + 4*((c + row) % 4)];
      st = tmp;
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
          st[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          st[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          st[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          st[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*r + i/4][31 - 8*(i%4) -: 8];
    end
    res = 128'h0;
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = st[i];
    return res;
  endfunction

  function automatic int predict_lat(input logic [127:0] k);
    return (cache_ok && (k == cache_key)) ? 12 : 22;
  endfunction

  // Present a block and return #1 after the edge that accepted it.
  task automatic send(input logic [127:0] k, input logic [127:0] ct);
    int g;
    g        = 0;
    in_valid = 1'b1;
    in_block = ct;
    key      = k;
    while (!in_ready && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    check_val("accept_ready", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    cache_key = k;
    cache_ok  = 1'b1;
  endtask

  task automatic wait_out(input string tag, input int exp_lat);
    int lat;
    lat = 1;
    for (int g = 0; g < 100 && !out_valid; g++) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    check_val({tag, "_valid"}, 128'(out_valid), 128'd1);
  endtask

  task automatic take_out(input string tag, input logic [127:0] exp_pt, input int stall_pct);
    check_val({tag, "_pt"}, out_block, exp_pt);
    for (int g = 0; g < 200; g++) begin
      out_ready = (g == 199) || ($urandom_range(0, 99) >= stall_pct);
      @(posedge clk); #1;
      if (out_ready) break;
    end
    out_ready = 1'b0;
    check_val({tag, "_valid_drop"}, 128'(out_valid), 128'd0);
    check_val({tag, "_hold"}, out_block, exp_pt);
  endtask

  task automatic run_block(input string tag, input logic [127:0] k, input logic [127:0] ct,
                           input logic [127:0] pt, input int exp_lat, input int stall_pct);
    send(k, ct);
    wait_out(tag, exp_lat);
    take_out(tag, pt, stall_pct);
  endtask

  // Accept a block, pull rst_n low for the given edge (accept edge = 0), check recovery.
  task automatic reset_at(input string tag, input logic [127:0] k, input logic [127:0] ct, input int edge_n);
    send(k, ct);
    repeat (edge_n - 1) @(posedge clk);
    #1; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n    = 1'b1;
    cache_ok = 1'b0;
    check_val({tag, "_in_ready"}, 128'(in_ready), 128'd1);
    check_val({tag, "_out_valid"}, 128'(out_valid), 128'd0);
    check_val({tag, "_out_block"}, out_block, 128'h0);
    repeat (30) @(posedge clk);
    #1;
    check_val({tag, "_no_output"}, 128'(out_valid), 128'd0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k_v;
    logic [127:0] pt_v;
    logic [127:0] ct_v;
    logic [127:0] prev_k;
    n_tests   = 0;
    n_fail    = 0;
    cache_ok  = 1'b0;
    cache_key = 128'h0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_block  = 128'h0;
    key       = 128'h0;
    out_ready = 1'b0;
    build_sbox();
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;

    check_val("reset_in_ready", 128'(in_ready), 128'd1);
    check_val("reset_out_valid", 128'(out_valid), 128'd0);
    check_val("reset_out_block", out_block, 128'h0);
    check_val("model_c1", aes_enc(K1, PT1), CT1);
    check_val("model_b", aes_enc(K2, PT2), CT2);

    // Known-answer vectors and key-cache hit/miss latencies.
    run_block("c1", K1, CT1, PT1, 22, 0);
    run_block("b", K2, CT2, PT2, 22, 0);
    run_block("b_hit", K2, CT2, PT2, 12, 0);
    run_block("c1_miss", K1, CT1, PT1, 22, 0);

    // Backpressure with a competing request held on the input.
    send(K1, CT1);
    wait_out("bp", 12);
    in_valid = 1'b1;
    in_block = CT2;
    key      = K2;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      check_val("bp_valid_held", 128'(out_valid), 128'd1);
      check_val("bp_block_held", out_block, PT1);
      check_val("bp_in_ready_low", 128'(in_ready), 128'd0);
    end
    in_valid = 1'b0;
    take_out("bp", PT1, 0);
    check_val("bp_idle_ready", 128'(in_ready), 128'd1);
    repeat (25) @(posedge clk);
    #1;
    check_val("bp_no_second", 128'(out_valid), 128'd0);

    // Reset in KEYEXP (cycle 5), then in ROUND at rnd 4 of a cache-hit block.
    reset_at("rst_keyexp", K2, CT2, 5);
    run_block("after_rst1", K2, CT2, PT2, 22, 0);
    reset_at("rst_round", K2, CT2, 7);
    run_block("after_rst2", K2, CT2, PT2, 22, 0);

    // Random round trips with key reuse and output stalls.
    prev_k = K2;
    for (int i = 0; i < 1000; i++) begin
      k_v  = ($urandom_range(0, 2) == 0) ? prev_k : {$urandom(), $urandom(), $urandom(), $urandom()};
      pt_v = {$urandom(), $urandom(), $urandom(), $urandom()};
      ct_v = aes_enc(k_v, pt_v);
      run_block("roundtrip", k_v, ct_v, pt_v, predict_lat(k_v), 25);
      prev_k = k_v;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
